cpu_datapath: RTL and testbench

Datapath end of the sequence-controller control interface for the 8-bit accumulator CPU. It consumes the controller's per-cycle strobes (mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr) and holds the PC, IR and accumulator, plus the ALU and the address mux. It drives the memory bus and returns op and zero to the controller. It tracks the controller's 8-cycle instruction sequence with its own phase counter.

---
 rtl/cpu_datapath.sv | 82 ++++++++
 tb/tb_cpu_datapath.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Datapath half of the 8-bit accumulator CPU: PC, IR, AC, ALU and address mux,
// stepped by the sequence controller's per-cycle strobes.
module cpu_datapath #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              load_ir,
    input  logic              halt,
    input  logic              inc_pc,
    input  logic              load_ac,
    input  logic              load_pc,
    input  logic              mem_wr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [2:0]        op,
    output logic              zero,
    output logic              halted,
    output logic [AWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] ac
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;

    logic [2:0]        phase;
    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] alu_out;

    // ADD deliberately drops the carry; the CPU has no carry flag.
    function automatic logic [DWIDTH-1:0] alu(input logic [2:0]        f_op,
                                               input logic [DWIDTH-1:0] a,
                                               input logic [DWIDTH-1:0] b);
        case (f_op)
            OP_ADD:  alu = a + b;
            OP_AND:  alu = a & b;
            OP_XOR:  alu = a ^ b;
            OP_LDA:  alu = b;
            default: alu = a;
        endcase
    endfunction

    assign op        = ir[DWIDTH-1 -: 3];
    assign alu_out   = alu(op, ac, mem_rdata);
    assign zero      = (ac == '0);
    assign mem_wdata = ac;
    assign mem_re    = mem_rd & ~halted;
    assign mem_we    = mem_wr & ~halted;
    // phase[2] separates fetch (0-3, address from PC) from execute (4-7, IR operand).
    assign mem_addr  = phase[2] ? ir[AWIDTH-1:0] : pc;

    // Once halted is set every register holds until reset; the halting edge itself still acts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            ir     <= '0;
            ac     <= '0;
            phase  <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            phase <= phase + 3'd1;
            if (halt)
                halted <= 1'b1;
            if (load_pc)
                pc <= ir[AWIDTH-1:0];
            else if (inc_pc)
                pc <= pc + AWIDTH'(1);
            if (load_ir)
                ir <= mem_rdata;
            if (load_ac)
                ac <= alu_out;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scenario bench for cpu_datapath: expectations are queued as stimulus is driven
// and popped for comparison once the design has responded.
module tb_cpu_datapath;

    localparam int AW = 5;
    localparam int DW = 8;

    localparam logic [6:0] S_RD   = 7'b1000000;
    localparam logic [6:0] S_IR   = 7'b0100000;
    localparam logic [6:0] S_HALT = 7'b0010000;
    localparam logic [6:0] S_INC  = 7'b0001000;
    localparam logic [6:0] S_AC   = 7'b0000100;
    localparam logic [6:0] S_PC   = 7'b0000010;
    localparam logic [6:0] S_NONE = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_rd = 1'b0, load_ir = 1'b0, halt = 1'b0, inc_pc = 1'b0;
    logic          load_ac = 1'b0, load_pc = 1'b0, mem_wr = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re, mem_we, zero, halted;
    logic [2:0]    op;
    logic [AW-1:0] pc;
    logic [DW-1:0] ac;

    logic [7:0] sb[$];
    logic [7:0] e;
    int n_cmp = 0;
    int n_bad = 0;

    cpu_datapath #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
        .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .op(op), .zero(zero),
        .halted(halted), .pc(pc), .ac(ac)
    );

    always #5 clk = ~clk;

    // One clock with the given strobes; returns 1 time unit after the edge with strobes cleared.
    task automatic cyc(input logic [6:0] s, input logic [7:0] rd);
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = s;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = S_NONE;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01);
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL por_pc: got %h want %h", pc, e); end
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL por_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(zero) !== e) begin n_bad++; $display("FAIL por_zero: got %h want %h", zero, e); end
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL por_addr: got %h want %h", mem_addr, e); end
        e = sb.pop_front(); n_cmp++; if (mem_wdata !== e) begin n_bad++; $display("FAIL por_wdata: got %h want %h", mem_wdata, e); end
        e = sb.pop_front(); n_cmp++; if (8'(halted) !== e) begin n_bad++; $display("FAIL por_halted: got %h want %h", halted, e); end
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        cyc(S_IR, 8'h0A);
        cyc(S_PC, 8'h00);
        cyc(S_IR, 8'hA0);
        cyc(S_AC, 8'h33);
        cyc(S_NONE, 8'h00);
        sb.push_back(8'h0A); sb.push_back(8'h33); sb.push_back(8'h00);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL mid_pc_pre: got %h want %h", pc, e); end
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL mid_ac_pre: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL mid_addr_ph5: got %h want %h", mem_addr, e); end
        rst = 1'b0;
        #1;
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h00);
        sb.push_back(8'h00); sb.push_back(8'h00);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL mid_pc: got %h want %h", pc, e); end
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL mid_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(zero) !== e) begin n_bad++; $display("FAIL mid_zero: got %h want %h", zero, e); end
        e = sb.pop_front(); n_cmp++; if (8'(op) !== e) begin n_bad++; $display("FAIL mid_op: got %h want %h", op, e); end
        e = sb.pop_front(); n_cmp++; if (8'({mem_re, mem_we}) !== e) begin n_bad++; $display("FAIL mid_re_we: got %b%b want %h", mem_re, mem_we, e); end
        e = sb.pop_front(); n_cmp++; if (8'(halted) !== e) begin n_bad++; $display("FAIL mid_halted: got %h want %h", halted, e); end
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_fetch_decode();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(S_INC, 8'h00);
        for (int i = 0; i < 5; i++) cyc(S_NONE, 8'h00);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(8'h03);
            e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL fetch_addr_ph%0d: got %h want %h", i, mem_addr, e); end
            cyc(S_NONE, 8'h00);
        end
        sb.push_back(8'h03);
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL fetch_addr_ph2: got %h want %h", mem_addr, e); end
        cyc(S_IR, 8'h45);
        sb.push_back(8'h02); sb.push_back(8'h03);
        e = sb.pop_front(); n_cmp++; if (8'(op) !== e) begin n_bad++; $display("FAIL decode_op: got %h want %h", op, e); end
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL fetch_addr_ph3: got %h want %h", mem_addr, e); end
        cyc(S_NONE, 8'h00);
        sb.push_back(8'h05);
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL exec_addr_ph4: got %h want %h", mem_addr, e); end
    endtask

    // Continues from test_fetch_decode: IR holds ADD (0x45), AC is 0.
    task automatic test_alu();
        cyc(S_AC, 8'hF0);
        cyc(S_AC, 8'h20);
        sb.push_back(8'h10); sb.push_back(8'h00);
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL add_wrap_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(zero) !== e) begin n_bad++; $display("FAIL add_wrap_zero: got %h want %h", zero, e); end
        cyc(S_AC, 8'hEF);
        cyc(S_AC, 8'h01);
        sb.push_back(8'h00); sb.push_back(8'h01);
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL add_zero_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(zero) !== e) begin n_bad++; $display("FAIL add_zero_zero: got %h want %h", zero, e); end
        cyc(S_IR | S_AC, 8'h7F);
        sb.push_back(8'h7F); sb.push_back(8'h03);
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL ir_ac_same_edge_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(op) !== e) begin n_bad++; $display("FAIL ir_ac_same_edge_op: got %h want %h", op, e); end
        cyc(S_AC, 8'h0F);
        sb.push_back(8'h0F);
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL and_ac: got %h want %h", ac, e); end
        cyc(S_IR, 8'h80);
        cyc(S_AC, 8'hFF);
        sb.push_back(8'hF0);
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL xor_ac: got %h want %h", ac, e); end
        cyc(S_IR, 8'h20);
        cyc(S_AC, 8'h55);
        sb.push_back(8'hF0); sb.push_back(8'hF0);
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL nop_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (mem_wdata !== e) begin n_bad++; $display("FAIL wdata_follows_ac: got %h want %h", mem_wdata, e); end
    endtask

    task automatic test_pc();
        cyc(S_IR, 8'hE9);
        cyc(S_PC | S_INC, 8'h00);
        sb.push_back(8'h09);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL pc_priority: got %h want %h", pc, e); end
        cyc(S_IR, 8'h1F);
        cyc(S_PC, 8'h00);
        cyc(S_INC, 8'h00);
        sb.push_back(8'h00);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL pc_wrap: got %h want %h", pc, e); end
    endtask

    task automatic test_store();
        do_reset();
        cyc(S_IR, 8'hA0);
        cyc(S_AC, 8'h5A);
        cyc(S_IR, 8'hCC);
        for (int i = 0; i < 4; i++) cyc(S_NONE, 8'h00);
        mem_wr = 1'b1;
        #1;
        sb.push_back(8'h01); sb.push_back(8'h0C); sb.push_back(8'h5A);
        e = sb.pop_front(); n_cmp++; if (8'(mem_we) !== e) begin n_bad++; $display("FAIL store_we: got %h want %h", mem_we, e); end
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL store_addr: got %h want %h", mem_addr, e); end
        e = sb.pop_front(); n_cmp++; if (mem_wdata !== e) begin n_bad++; $display("FAIL store_wdata: got %h want %h", mem_wdata, e); end
        mem_wr = 1'b0;
        mem_rd = 1'b1;
        #1;
        sb.push_back(8'h00); sb.push_back(8'h01);
        e = sb.pop_front(); n_cmp++; if (8'(mem_we) !== e) begin n_bad++; $display("FAIL store_we_off: got %h want %h", mem_we, e); end
        e = sb.pop_front(); n_cmp++; if (8'(mem_re) !== e) begin n_bad++; $display("FAIL read_re: got %h want %h", mem_re, e); end
        mem_rd = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        cyc(S_IR | S_INC, 8'hB1);
        for (int i = 0; i < 5; i++) cyc(S_INC, 8'h00);
        for (int i = 0; i < 6; i++) cyc(S_NONE, 8'h00);
        cyc(S_HALT | S_INC, 8'h00);
        sb.push_back(8'h07); sb.push_back(8'h01);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL halt_edge_pc: got %h want %h", pc, e); end
        e = sb.pop_front(); n_cmp++; if (8'(halted) !== e) begin n_bad++; $display("FAIL halt_edge_halted: got %h want %h", halted, e); end
        for (int i = 0; i < 10; i++) cyc(S_RD | S_IR | S_AC | S_INC | S_PC, 8'h77);
        mem_rd = 1'b1;
        mem_wr = 1'b1;
        #1;
        sb.push_back(8'h07); sb.push_back(8'h00); sb.push_back(8'h11);
        sb.push_back(8'h05); sb.push_back(8'h00); sb.push_back(8'h01);
        e = sb.pop_front(); n_cmp++; if (8'(pc) !== e) begin n_bad++; $display("FAIL halted_pc: got %h want %h", pc, e); end
        e = sb.pop_front(); n_cmp++; if (ac !== e) begin n_bad++; $display("FAIL halted_ac: got %h want %h", ac, e); end
        e = sb.pop_front(); n_cmp++; if (8'(mem_addr) !== e) begin n_bad++; $display("FAIL halted_phase_addr: got %h want %h", mem_addr, e); end
        e = sb.pop_front(); n_cmp++; if (8'(op) !== e) begin n_bad++; $display("FAIL halted_op: got %h want %h", op, e); end
        e = sb.pop_front(); n_cmp++; if (8'({mem_re, mem_we}) !== e) begin n_bad++; $display("FAIL halted_re_we: got %b%b want %h", mem_re, mem_we, e); end
        e = sb.pop_front(); n_cmp++; if (8'(halted) !== e) begin n_bad++; $display("FAIL halted_sticky: got %h want %h", halted, e); end
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        do_reset();
        sb.push_back(8'h00);
        e = sb.pop_front(); n_cmp++; if (8'(halted) !== e) begin n_bad++; $display("FAIL halt_cleared: got %h want %h", halted, e); end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_fetch_decode();
        test_alu();
        test_pc();
        test_store();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
